vx_mem_perf_counter: RTL and testbench
======================================

VX_MEM_PERF_COUNTER -- requirements
Module: VX_mem_perf_counter

Interface
REQ-001 SHALL have parameter PERF_CTR_BITS, default 44: width of every event counter.
REQ-002 SHALL have parameter MAX_PENDING, default 64: maximum in-flight memory reads tracked.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port perf_clear, input, 1: synchronous clear of event counters.
REQ-006 SHALL have port mem_req_valid, input, 1: memory request valid.
REQ-007 SHALL have port mem_req_ready, input, 1: memory request ready.
REQ-008 SHALL have port mem_req_rw, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port mem_rsp_valid, input, 1: read response valid.
REQ-010 SHALL have port mem_rsp_ready, input, 1: read response ready.
REQ-011 SHALL have ports mem_reads, mem_writes and mem_latency, output, PERF_CTR_BITS each, driving the same-named fields of the memsys perf interface master modport.
REQ-012 SHALL have port pending_reads, output, $clog2(MAX_PENDING+1): current in-flight read count.
REQ-013 SHALL have port err_overflow, output, 1: sticky; a read was issued while pending_reads = MAX_PENDING.
REQ-014 SHALL have port err_underflow, output, 1: sticky; a response arrived while pending_reads = 0.

Function
REQ-015 SHALL define req_fire = mem_req_valid & mem_req_ready, and rsp_fire = mem_rsp_valid & mem_rsp_ready.
REQ-016 SHALL increment mem_reads by 1 on each req_fire with mem_req_rw = 0; the output reflects it 1 cycle after the fire edge.
REQ-017 SHALL increment mem_writes by 1 on each req_fire with mem_req_rw = 1; latency 1 cycle.
REQ-018 SHALL update pending_reads each cycle by +1 for a read fire and -1 for rsp_fire; a simultaneous read fire and rsp_fire leave it unchanged.
REQ-019 SHALL add the pre-update pending_reads value to mem_latency each cycle, zero-extended to PERF_CTR_BITS.
REQ-020 SHALL saturate pending_reads at MAX_PENDING: a read fire (without rsp_fire) at MAX_PENDING holds the value and sets err_overflow.
REQ-021 SHALL hold pending_reads at 0 when rsp_fire occurs (without a read fire) at 0, and set err_underflow.
REQ-022 SHALL wrap mem_reads, mem_writes and mem_latency modulo 2^PERF_CTR_BITS, with no saturation and no flag.
REQ-023 SHALL, when perf_clear = 1, load 0 into mem_reads, mem_writes and mem_latency on the next edge; events in that cycle are dropped (clear has priority).
REQ-024 SHALL NOT let perf_clear affect pending_reads or the error flags; pending tracking continues normally in that cycle.
REQ-025 SHALL keep err_overflow and err_underflow set until reset.
REQ-026 SHALL drive all outputs directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, while reset = 0, asynchronously force all counters, pending_reads and both error flags to 0.
REQ-028 SHALL resume counting on the first rising clk edge after reset deasserts; in-flight reads from before reset are forgotten, and their responses raise err_underflow.

Structure
REQ-029 SHALL take PERF_CTR_BITS from the shared global define header; MAX_PENDING stays a module parameter.
REQ-030 SHALL place a shared constant PERF_PENDING_BITS(n) = $clog2(n+1) in the shared package.
REQ-031 SHALL instantiate one sub-module, VX_pending_size (up/down saturating counter with overflow/underflow pulses), for pending_reads.

Verification
REQ-032 SHALL cover: 3 read fires then 2 write fires, no responses -> mem_reads = 3, mem_writes = 2, pending_reads = 3.
REQ-033 SHALL cover: 1 read fire, response 4 cycles later -> mem_latency = 4 and pending_reads = 0.
REQ-034 SHALL cover: read fire and rsp_fire in the same cycle with pending_reads = 2 -> pending_reads stays 2, mem_reads +1.
REQ-035 SHALL cover: MAX_PENDING = 4, 5 back-to-back reads -> pending_reads = 4, err_overflow = 1 and held; mem_reads = 5.
REQ-036 SHALL cover: perf_clear asserted in the same cycle as a write fire, with mem_writes = 7 -> mem_writes = 0 next cycle, pending_reads unchanged.
REQ-037 SHALL cover: reset asserted mid-operation with pending_reads = 3 -> all outputs 0 immediately; a following rsp_fire sets err_underflow.

Source files
------------

// File: rtl/vx_mem_perf_counter_pkg.sv
// Shared constants for the memory performance counters.
// Counter width and pending-count sizing helper.
package vx_mem_perf_counter_pkg;

  localparam int VX_PERF_CTR_BITS = 44;

  function automatic int perf_pending_bits(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vx_mem_perf_if.sv
// Memory-system perf counter bundle.
// Master drives the counts, slave observes them.
interface vx_mem_perf_if #(
  parameter int W = 44
);

  logic [W-1:0] mem_reads;
  logic [W-1:0] mem_writes;
  logic [W-1:0] mem_latency;

  modport master (
    output mem_reads,
    output mem_writes,
    output mem_latency
  );

  modport slave (
    input mem_reads,
    input mem_writes,
    input mem_latency
  );

endinterface

// File: rtl/vx_pending_size.sv
// Saturating up/down in-flight counter.
// Overflow/underflow are same-cycle pulses for the parent to latch.
module vx_pending_size
  import vx_mem_perf_counter_pkg::*;
#(
  parameter int SIZE = 64,
  parameter int W    = perf_pending_bits(SIZE)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         incr,
  input  logic         decr,
  output logic [W-1:0] size,
  output logic         overflow,
  output logic         underflow
);

  logic full;
  logic empty;

  assign full      = (size == W'(SIZE));
  assign empty     = (size == '0);
  assign overflow  = incr & ~decr & full;
  assign underflow = decr & ~incr & empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      size <= '0;
    end else begin
      unique case (1'b1)
        incr & ~decr & ~full:  size <= size + W'(1);
        decr & ~incr & ~empty: size <= size - W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vx_mem_perf_counter.sv
// Memory read/write/latency event counters with
// in-flight read tracking and sticky error flags.
module vx_mem_perf_counter
  import vx_mem_perf_counter_pkg::*;
#(
  parameter int PERF_CTR_BITS = VX_PERF_CTR_BITS,
  parameter int MAX_PENDING   = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     perf_clear,
  input  logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  input  logic                     mem_req_rw,
  input  logic                     mem_rsp_valid,
  input  logic                     mem_rsp_ready,
  output logic [PERF_CTR_BITS-1:0] mem_reads,
  output logic [PERF_CTR_BITS-1:0] mem_writes,
  output logic [PERF_CTR_BITS-1:0] mem_latency,
  output logic [perf_pending_bits(MAX_PENDING)-1:0] pending_reads,
  output logic                     err_overflow,
  output logic                     err_underflow
);

  localparam int PW = perf_pending_bits(MAX_PENDING);

  logic                     req_fire;
  logic                     rsp_fire;
  logic                     rd_fire;
  logic                     wr_fire;
  logic                     ovf_pulse;
  logic                     udf_pulse;
  logic [PW-1:0]            pend;
  logic [PERF_CTR_BITS-1:0] reads_q;
  logic [PERF_CTR_BITS-1:0] writes_q;
  logic [PERF_CTR_BITS-1:0] lat_q;

  vx_mem_perf_if #(.W(PERF_CTR_BITS)) perf_if ();

  assign req_fire = mem_req_valid & mem_req_ready;
  assign rsp_fire = mem_rsp_valid & mem_rsp_ready;
  assign rd_fire  = req_fire & ~mem_req_rw;
  assign wr_fire  = req_fire & mem_req_rw;

  vx_pending_size #(
    .SIZE (MAX_PENDING),
    .W    (PW)
  ) u_pending (
    .clk       (clk),
    .reset     (reset),
    .incr      (rd_fire),
    .decr      (rsp_fire),
    .size      (pend),
    .overflow  (ovf_pulse),
    .underflow (udf_pulse)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reads_q       <= '0;
      writes_q      <= '0;
      lat_q         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_overflow  <= err_overflow | ovf_pulse;
      err_underflow <= err_underflow | udf_pulse;
      // clear wins over any event in the same cycle
      if (perf_clear) begin
        reads_q  <= '0;
        writes_q <= '0;
        lat_q    <= '0;
      end else begin
        if (rd_fire)
          reads_q <= reads_q + PERF_CTR_BITS'(1);
        if (wr_fire)
          writes_q <= writes_q + PERF_CTR_BITS'(1);
        lat_q <= lat_q + PERF_CTR_BITS'(pend);
      end
    end
  end

  assign perf_if.mem_reads   = reads_q;
  assign perf_if.mem_writes  = writes_q;
  assign perf_if.mem_latency = lat_q;

  assign mem_reads     = perf_if.mem_reads;
  assign mem_writes    = perf_if.mem_writes;
  assign mem_latency   = perf_if.mem_latency;
  assign pending_reads = pend;

endmodule

// File: tb/tb_vx_mem_perf_counter.sv
// Bench for vx_mem_perf_counter: directed table, corner
// sequences and randomized traffic against a reference model.
module tb_vx_mem_perf_counter;

  localparam int CW  = 8;
  localparam int MP  = 4;
  localparam int PW  = $clog2(MP + 1);
  localparam int MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          rv = 1'b0;
  logic          rr = 1'b0;
  logic          rw = 1'b0;
  logic          sv = 1'b0;
  logic          sr = 1'b0;
  logic [CW-1:0] mem_reads;
  logic [CW-1:0] mem_writes;
  logic [CW-1:0] mem_latency;
  logic [PW-1:0] pending_reads;
  logic          err_overflow;
  logic          err_underflow;

  int errors = 0;
  int checks = 0;

  int m_reads, m_writes, m_lat, m_pend;
  bit m_ovf, m_udf;

  vx_mem_perf_counter #(
    .PERF_CTR_BITS (CW),
    .MAX_PENDING   (MP)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .perf_clear    (clr),
    .mem_req_valid (rv),
    .mem_req_ready (rr),
    .mem_req_rw    (rw),
    .mem_rsp_valid (sv),
    .mem_rsp_ready (sr),
    .mem_reads     (mem_reads),
    .mem_writes    (mem_writes),
    .mem_latency   (mem_latency),
    .pending_reads (pending_reads),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_reads = 0; m_writes = 0; m_lat = 0; m_pend = 0;
    m_ovf = 0; m_udf = 0;
  endtask

  // One clock edge of the spec's rules, applied to current inputs.
  task automatic model_edge();
    bit rd, wr, rsp;
    int p;
    rd  = rv && rr && !rw;
    wr  = rv && rr && rw;
    rsp = sv && sr;
    p   = m_pend;
    if (clr) begin
      m_reads = 0; m_writes = 0; m_lat = 0;
    end else begin
      if (rd) m_reads = (m_reads + 1) % MOD;
      if (wr) m_writes = (m_writes + 1) % MOD;
      m_lat = (m_lat + p) % MOD;
    end
    if (rd && !rsp) begin
      if (p == MP) m_ovf = 1;
      else m_pend = p + 1;
    end else if (rsp && !rd) begin
      if (p == 0) m_udf = 1;
      else m_pend = p - 1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".reads"}, int'(mem_reads), m_reads);
    chk({tag, ".writes"}, int'(mem_writes), m_writes);
    chk({tag, ".latency"}, int'(mem_latency), m_lat);
    chk({tag, ".pending"}, int'(pending_reads), m_pend);
    chk({tag, ".ovf"}, int'(err_overflow), int'(m_ovf));
    chk({tag, ".udf"}, int'(err_underflow), int'(m_udf));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic drive(input bit v, input bit r, input bit w,
                       input bit s, input bit q, input bit c);
    rv = v; rr = r; rw = w; sv = s; sr = q; clr = c;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #3;
    model_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit v, r, w, s, q, c;
    int reads, writes, pend, lat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1,1,0, 0,0,0, 1,0,1,0};
    tbl[1] = '{1,1,0, 0,0,0, 2,0,2,1};
    tbl[2] = '{1,1,0, 0,0,0, 3,0,3,3};
    tbl[3] = '{1,1,1, 0,0,0, 3,1,3,6};
    tbl[4] = '{1,1,1, 0,0,0, 3,2,3,9};
    tbl[5] = '{1,0,0, 0,0,0, 3,2,3,12};
    tbl[6] = '{0,0,0, 1,1,0, 3,2,2,15};
    tbl[7] = '{1,1,0, 1,1,0, 4,2,2,17};
    tbl[8] = '{0,0,0, 1,1,0, 4,2,1,19};
    tbl[9] = '{0,0,0, 1,0,0, 4,2,1,20};

    #2;
    model_reset();
    #1;
    chk("reset.reads", int'(mem_reads), 0);
    chk("reset.pending", int'(pending_reads), 0);
    chk("reset.ovf", int'(err_overflow), 0);
    do_reset();

    // Directed table: reads, writes, simultaneous read+rsp.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].w, tbl[i].s, tbl[i].q, tbl[i].c);
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.reads", i), int'(mem_reads), tbl[i].reads);
      chk($sformatf("tbl%0d.writes", i), int'(mem_writes), tbl[i].writes);
      chk($sformatf("tbl%0d.pend", i), int'(pending_reads), tbl[i].pend);
      chk($sformatf("tbl%0d.lat", i), int'(mem_latency), tbl[i].lat);
    end

    // Single read, response on the fourth following edge.
    do_reset();
    drive(1, 1, 0, 0, 0, 0);
    step("lat.req");
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("lat.wait");
    drive(0, 0, 0, 1, 1, 0);
    step("lat.rsp");
    drive(0, 0, 0, 0, 0, 0);
    chk("lat.latency", int'(mem_latency), 4);
    chk("lat.pending", int'(pending_reads), 0);

    // Overflow: five back-to-back reads into a depth of four.
    do_reset();
    drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("ovf.req");
    drive(0, 0, 0, 0, 0, 0);
    step("ovf.idle");
    step("ovf.idle");
    chk("ovf.pending", int'(pending_reads), 4);
    chk("ovf.flag", int'(err_overflow), 1);
    chk("ovf.reads", int'(mem_reads), 5);

    // Clear colliding with a write at mem_writes = 7.
    do_reset();
    drive(1, 1, 0, 0, 0, 0);
    step("clr.rd");
    drive(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step("clr.wr");
    chk("clr.pre", int'(mem_writes), 7);
    drive(1, 1, 1, 0, 0, 1);
    step("clr.hit");
    drive(0, 0, 0, 0, 0, 0);
    chk("clr.writes", int'(mem_writes), 0);
    chk("clr.pending", int'(pending_reads), 1);

    // Reset mid-operation, then a stray response.
    do_reset();
    drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("rst.rd");
    chk("rst.pre", int'(pending_reads), 3);
    rst_n = 1'b0;
    #1;
    chk("rst.async.reads", int'(mem_reads), 0);
    chk("rst.async.lat", int'(mem_latency), 0);
    chk("rst.async.pend", int'(pending_reads), 0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 1, 0);
    step("rst.rsp");
    drive(0, 0, 0, 0, 0, 0);
    chk("rst.udf", int'(err_underflow), 1);

    // Randomized traffic, wrapping the narrow counters.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 60) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
